// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures instruction memory data into an instruction
// register and hands it to decode over valid/ready, with stall, branch flush and halt.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR   = 5,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  input  logic [DATA_WIDTH-1:0] instruction_data,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  decode_ready,
  output logic                  halted,
  output logic [7:0]            fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] ipc_q;
  logic                  valid_q;
  logic                  halted_q;
  logic [7:0]            count_q;

  logic slot_free;
  logic handshake;

  assign slot_free = !valid_q || decode_ready;
  assign handshake = valid_q && decode_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // Handshake counting is independent of the redirect/capture decision below.
      if (handshake && (count_q != 8'hFF)) begin
        count_q <= count_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (branch_taken) begin
            pc_q    <= branch_target;
            valid_q <= 1'b0;
          end else if (slot_free) begin
            instr_q <= instruction_data;
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + 1'b1;
            if ((instruction_data == HALT_OPCODE) || (pc_q == LAST_ADDR)) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (handshake) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instruction_address = pc_q;
  assign instr_out           = instr_q;
  assign instr_pc            = ipc_q;
  assign instr_valid         = valid_q;
  assign halted              = halted_q;
  assign fetch_count         = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural fetch model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset, start, branch_taken, decode_ready;
  logic [7:0] branch_target;
  logic [7:0] instruction_address, instruction_data;
  logic [7:0] instr_out, instr_pc, fetch_count;
  logic       instr_valid, halted;

  logic [7:0] mem [8];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch stage
  logic       m_run, m_stop, m_valid;
  logic [7:0] m_pc, m_out, m_opc;
  int         m_cnt;

  always #5 clk = ~clk;

  always_comb begin
    instruction_data = (instruction_address < 8'd6) ? mem[instruction_address[2:0]] : 8'h5A;
  end

  instruction_fetch #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .RESET_PC   (8'h00),
    .LAST_ADDR  (8'h05),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .instruction_address(instruction_address),
    .instruction_data   (instruction_data),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .instr_out          (instr_out),
    .instr_pc           (instr_pc),
    .instr_valid        (instr_valid),
    .decode_ready       (decode_ready),
    .halted             (halted),
    .fetch_count        (fetch_count)
  );

  function automatic logic [7:0] rd(input logic [7:0] a);
    return (a < 8'd6) ? mem[a[2:0]] : 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    chk("instruction_address", instruction_address, m_pc);
    chk("instr_valid", {7'd0, instr_valid}, {7'd0, m_valid});
    chk("halted", {7'd0, halted}, {7'd0, m_stop});
    chk("fetch_count", fetch_count, m_cnt[7:0]);
    chk("instr_out", instr_out, m_out);
    chk("instr_pc", instr_pc, m_opc);
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic step();
    logic [7:0] d;
    logic       hs;
    hs = m_valid && decode_ready;
    if (reset) begin
      m_run = 0; m_stop = 0; m_valid = 0;
      m_pc = 8'h00; m_out = 8'h00; m_opc = 8'h00; m_cnt = 0;
    end else begin
      if (hs && m_cnt < 255) m_cnt++;
      if (m_stop) begin
        if (hs) m_valid = 0;
      end else if (!m_run) begin
        m_run = start;
      end else if (branch_taken) begin
        m_valid = 0;
        m_pc = branch_target;
      end else if (!m_valid || decode_ready) begin
        d = rd(m_pc);
        m_out = d;
        m_opc = m_pc;
        m_valid = 1;
        if (d == 8'hFF || m_pc == 8'h05) m_stop = 1;
        m_pc = m_pc + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic load_seq();
    for (int unsigned i = 0; i < 8; i++) mem[i] = 8'(i + 1);
  endtask

  task automatic do_reset_start();
    reset = 1; start = 0; branch_taken = 0;
    step();
    reset = 0; start = 1;
    step();
    start = 0;
  endtask

  initial begin
    int exp_cnt;
    reset = 1; start = 0; branch_taken = 0; branch_target = 8'h00; decode_ready = 0;
    m_run = 0; m_stop = 0; m_valid = 0; m_pc = 0; m_out = 0; m_opc = 0; m_cnt = 0;
    load_seq();
    @(negedge clk);
    step();
    step();
    chk("reset_valid", {7'd0, instr_valid}, 8'd0);
    chk("reset_addr", instruction_address, 8'd0);

    // Straight-line program at full throughput
    decode_ready = 1;
    do_reset_start();
    chk("start_latency_valid", {7'd0, instr_valid}, 8'd0);
    step();
    chk("first_word", instr_out, 8'h01);
    repeat (7) step();
    chk("t1_count", fetch_count, 8'd6);
    chk("t1_halted", {7'd0, halted}, 8'd1);
    chk("t1_addr", instruction_address, 8'd6);

    // Stall while 02 is held
    do_reset_start();
    decode_ready = 1;
    step();
    step();
    decode_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_out", instr_out, 8'h02);
      chk("t2_pc", instr_pc, 8'h01);
      chk("t2_addr", instruction_address, 8'h02);
    end
    decode_ready = 1;
    step();
    chk("t2_resume", instr_out, 8'h03);

    // Branch flush
    do_reset_start();
    step();
    step();
    decode_ready = 0;
    branch_taken = 1; branch_target = 8'h04;
    step();
    chk("t3_valid", {7'd0, instr_valid}, 8'd0);
    chk("t3_addr", instruction_address, 8'h04);
    branch_taken = 0;
    step();
    chk("t3_out", instr_out, 8'h05);
    chk("t3_pc", instr_pc, 8'h04);
    decode_ready = 1;

    // HALT opcode
    mem[1] = 8'hFF;
    do_reset_start();
    repeat (4) step();
    start = 1; branch_taken = 1; branch_target = 8'h00;
    repeat (3) step();
    start = 0; branch_taken = 0;
    chk("t4_halted", {7'd0, halted}, 8'd1);
    chk("t4_addr", instruction_address, 8'h02);
    chk("t4_count", fetch_count, 8'd2);
    load_seq();

    // Reset mid-stall
    do_reset_start();
    step();
    decode_ready = 0;
    step();
    reset = 1;
    step();
    chk("t5_valid", {7'd0, instr_valid}, 8'd0);
    chk("t5_count", fetch_count, 8'd0);
    reset = 0; decode_ready = 1;
    repeat (3) step();
    chk("t5_idle_addr", instruction_address, 8'd0);

    // Branch with simultaneous handshake
    start = 1;
    step();
    start = 0;
    step();
    step();
    exp_cnt = m_cnt + 1;
    branch_taken = 1; branch_target = 8'h03;
    step();
    branch_taken = 0;
    chk("t6_count", fetch_count, 8'(exp_cnt));
    chk("t6_valid", {7'd0, instr_valid}, 8'd0);
    chk("t6_addr", instruction_address, 8'h03);

    // Saturation: loop on addresses 0..2 without halting
    do_reset_start();
    for (int i = 0; i < 400; i++) begin
      branch_taken = (i % 3 == 2);
      branch_target = 8'h00;
      step();
    end
    branch_taken = 0;
    chk("sat_count", fetch_count, 8'd255);

    // Random traffic, including branches near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (reset) begin
        for (int unsigned k = 0; k < 8; k++)
          mem[k] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      end
      start = ($urandom_range(0, 9) == 0);
      decode_ready = ($urandom_range(0, 9) < 7);
      branch_taken = ($urandom_range(0, 7) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255))
                                                  : 8'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the 8-bit instruction_address to the combinational instruction memory.
- Captures the returned instruction_data into an instruction register, and hands it to decode over a valid/ready handshake.
- Supports start, stall on decode backpressure, branch redirect with flush, and halt on a HALT opcode or end of program.

Parameters:
ADDR_WIDTH, 8, width of program counter and instruction_address
DATA_WIDTH, 8, width of instruction word
RESET_PC, 0, program counter value after reset
LAST_ADDR, 5, final valid instruction address (memory holds 6 words); fetching it ends the program
HALT_OPCODE, 8'hFF, instruction value that stops fetching

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; leaves IDLE and begins fetching
instruction_address  output  ADDR_WIDTH  current PC, driven straight from the pc register to instruction memory
instruction_data  input  DATA_WIDTH  combinational read data from instruction memory, valid in the same cycle
branch_taken  input  1  redirect request from execute
branch_target  input  ADDR_WIDTH  new PC when branch_taken=1
instr_out  output  DATA_WIDTH  registered instruction presented to decode
instr_pc  output  ADDR_WIDTH  address the instr_out word was fetched from
instr_valid  output  1  instr_out holds an undelivered instruction
decode_ready  input  1  decode accepts instr_out this cycle when instr_valid=1
halted  output  1  fetch has stopped (HALT opcode or LAST_ADDR fetched)
fetch_count  output  8  number of completed valid&ready handshakes, saturates at 255

Behaviour:
- Reset (sync, active-high, when reset=1 at a clk edge) sets:
  - state=IDLE, pc=RESET_PC
  - instr_out=0, instr_pc=0, instr_valid=0
  - halted=0, fetch_count=0
  - reset has priority over every other input, including mid-fetch and mid-stall.
- instruction_address = pc at all times. It is registered, so there is no combinational path from any input to it.
- States:
  - IDLE: no capture; pc holds. start=1 -> RUN. branch_taken is ignored.
  - RUN: fetch as below.
  - HALTED: halted=1; no capture; pc holds; start and branch_taken ignored. Any undelivered instruction still drains: instr_valid clears on its handshake. Only reset exits.
- slot_free = !instr_valid | decode_ready.
- RUN, priority order each cycle:
  1. branch_taken=1:
     - pc<=branch_target; instr_valid<=0, flushing the held word even if decode_ready=1 that cycle.
     - That flushed word counts only if the handshake occurred (valid&ready).
     - No capture this cycle.
  2. else if slot_free:
     - instr_out<=instruction_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2^ADDR_WIDTH).
     - If instruction_data==HALT_OPCODE or pc==LAST_ADDR -> HALTED after this capture. The captured word is still delivered.
  3. else (instr_valid & !decode_ready): stall; pc, instr_out, instr_pc, instr_valid all hold.
- Throughput: one instruction per cycle while decode_ready=1.
- Latency: start at edge N -> first word (address RESET_PC) has instr_valid=1 after edge N+1.
- fetch_count increments on every cycle with instr_valid & decode_ready; it stays at 255 once reached.
- pc wrap: 8'hFF+1 -> 8'h00 (only reachable via branch_target beyond LAST_ADDR).
- instr_out/instr_pc are stable while instr_valid=1 & decode_ready=0.

Test Plan:
1. Memory = {01,02,03,04,05,06}; reset, start, decode_ready=1 -> instr_out 01..06 on consecutive cycles with instr_pc 0..5; halted=1 after the word at address 5; fetch_count=6; instruction_address holds at 6.
2. Same memory, decode_ready low for 3 cycles while instr_out=02 -> instr_out=02, instr_pc=1, instruction_address=2 held all 3 cycles; resume gives 03 next with no loss or duplicate.
3. branch_taken=1, branch_target=4 while instr_valid=1 (pc=2) -> next cycle instr_valid=0 and instruction_address=4; following cycle instr_out=05, instr_pc=4.
4. Memory = {01,FF,03,...} -> 01 then FF delivered; halted=1; 03 never presented; start and branch_taken afterwards have no effect.
5. Assert reset mid-stall with instr_valid=1 -> next edge: instr_valid=0, instruction_address=0, fetch_count=0, state IDLE (no fetch until start).
6. branch_taken and decode_ready both high with instr_valid=1 -> held word counted (fetch_count+1), no new capture, pc=branch_target.
